// File: rtl/seg_pkg.sv
// seg_pkg: shared types, constants and the alphanumeric glyph table for the
// seven-segment scan driver.
//   glyph_t     - 8-bit active-low segment pattern {p,g,f,e,d,c,b,a}
//   code_t      - 6-bit alphanumeric code (0-9, then letters A-Z as 10-35)
//   state_e     - output FSM states (dark gap / digit shown)
//   SEG_BLANK   - all segments off, decimal point included
//   GLYPH_MAX   - highest code with a glyph; anything above decodes to blank
//   GLYPH_TABLE - glyphs for codes 0..GLYPH_MAX
package seg_pkg;

    typedef logic [7:0] glyph_t;
    typedef logic [5:0] code_t;

    typedef enum logic {StGap, StShow} state_e;

    localparam glyph_t      SEG_BLANK = 8'hFF;
    localparam int unsigned GLYPH_MAX = 35;

    localparam glyph_t GLYPH_TABLE [GLYPH_MAX+1] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,  // 0-7
        8'h80, 8'h90,                                            // 8-9
        8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,                // A b C d E F
        8'hC2, 8'h8B, 8'hCF, 8'hE1, 8'h8A, 8'hC7,                // G h I J K L
        8'hC8, 8'hAB, 8'hA3, 8'h8C, 8'h98, 8'hAF,                // M n o P q r
        8'h92, 8'h87, 8'hC1, 8'hE3, 8'h95, 8'h89,                // S t U v W X
        8'h91, 8'hA4                                             // y Z
    };

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational code-to-glyph decoder.
// Ports:
//   code  - in  6-bit alphanumeric code
//   glyph - out active-low segment pattern; codes above GLYPH_MAX give SEG_BLANK
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [5:0] code,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        if (code <= code_t'(GLYPH_MAX)) begin
            glyph = GLYPH_TABLE[code];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment driver for DIGITS common-anode
// digits sharing one active-low segment bus, with per-digit decimal point,
// blanking, blinking and circular left scroll.
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   load          - strobe capturing all display inputs into shadow registers
//   alnum_bus     - 6-bit code per digit, digit 0 in the low bits (rightmost)
//   dp_mask       - per-digit decimal point enable
//   blank_mask    - per-digit force-dark
//   blink_mask    - per-digit blink enable
//   scroll_en     - level enable for the scroll offset
//   an            - registered anode enables, active-low, at most one low
//   seg           - registered segments {p,g,f,e,d,c,b,a}, active-low
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned CLK_DIV    = 100000,
    parameter int unsigned BLINK_DIV  = 256,
    parameter int unsigned SCROLL_DIV = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [6*DIGITS-1:0]   alnum_bus,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  scroll_en,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SCR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  offset_q, offset_d;
    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic [SCR_W-1:0]  scroll_cnt_q, scroll_cnt_d;
    logic              phase_q, phase_d;
    state_e            state_q, state_d;
    logic [5:0]        code_q [DIGITS];
    logic [DIGITS-1:0] dp_q, blank_q, blink_q;
    logic [DIGITS-1:0] an_d;
    logic [7:0]        seg_d;

    logic              tick;
    logic              scroll_step;
    logic [SUM_W-1:0]  off_sum, off_wrap;
    logic [SUM_W-1:0]  sel_sum, sel_wrap;
    logic [IDX_W-1:0]  sel_idx;
    logic [7:0]        glyph;
    logic              dark;

    assign tick        = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign scroll_step = tick && scroll_en && (scroll_cnt_q == SCR_W'(SCROLL_DIV - 1));

    // One spare bit keeps the sums exact before folding back into 0..DIGITS-1.
    assign off_sum  = {1'b0, offset_q} + SUM_W'(1);
    assign off_wrap = (off_sum >= SUM_W'(DIGITS)) ? off_sum - SUM_W'(DIGITS) : off_sum;
    assign sel_sum  = {1'b0, idx_q} + {1'b0, offset_q};
    assign sel_wrap = (sel_sum >= SUM_W'(DIGITS)) ? sel_sum - SUM_W'(DIGITS) : sel_sum;
    assign sel_idx  = sel_wrap[IDX_W-1:0];

    seg_glyph_rom u_rom (
        .code  (code_q[sel_idx]),
        .glyph (glyph)
    );

    // Mask bits follow the shadow digit, so attributes scroll with content.
    assign dark = blank_q[sel_idx] | (blink_q[sel_idx] & phase_q);

    always_comb begin
        div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
        idx_d        = idx_q;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        scroll_cnt_d = scroll_cnt_q;
        offset_d     = offset_q;

        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
            if (scroll_en) begin
                scroll_cnt_d = (scroll_cnt_q == SCR_W'(SCROLL_DIV - 1)) ? '0
                                                                        : scroll_cnt_q + 1'b1;
            end
        end

        if (load) begin
            offset_d = '0;
        end else if (scroll_step) begin
            offset_d = off_wrap[IDX_W-1:0];
        end
    end

    // GAP holds exactly one cycle after every tick; outputs follow the next state so
    // they line up with the registered an/seg.
    always_comb begin
        state_d = state_q;
        an_d    = '1;
        seg_d   = SEG_BLANK;
        unique case (state_q)
            StGap:  state_d = tick ? StGap : StShow;
            StShow: state_d = tick ? StGap : StShow;
            default: state_d = StGap;
        endcase
        if (state_d == StShow) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (!dark) begin
                seg_d    = glyph;
                seg_d[7] = glyph[7] & ~dp_q[sel_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            offset_q     <= '0;
            blink_cnt_q  <= '0;
            scroll_cnt_q <= '0;
            phase_q      <= 1'b0;
            state_q      <= StGap;
            dp_q         <= '0;
            blank_q      <= '1;
            blink_q      <= '0;
            an           <= '1;
            seg          <= SEG_BLANK;
            for (int i = 0; i < int'(DIGITS); i++) begin
                code_q[i] <= '0;
            end
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            offset_q     <= offset_d;
            blink_cnt_q  <= blink_cnt_d;
            scroll_cnt_q <= scroll_cnt_d;
            phase_q      <= phase_d;
            state_q      <= state_d;
            an           <= an_d;
            seg          <= seg_d;
            if (load) begin
                dp_q    <= dp_mask;
                blank_q <= blank_mask;
                blink_q <= blink_mask;
                for (int i = 0; i < int'(DIGITS); i++) begin
                    code_q[i] <= alnum_bus[6*i +: 6];
                end
            end
        end
    end

endmodule
